// File: rtl/rx_session_ctrl.sv
// RX session controller: sequences buffer clear, arm and receive phases for one
// burst session, with watchdog-driven retries, abort handling and error reporting.
module rx_session_ctrl #(
    parameter int BURST_SIZE_WIDTH = 16,
    parameter int RX_WD_DEPTH      = 4,
    parameter int MAX_RETRY        = 2,
    parameter int CLEAR_CYCLES     = 2
) (
    input  logic                        clk_in,
    input  logic                        rst,
    input  logic                        cmd_start,
    input  logic                        cmd_mode,
    input  logic [BURST_SIZE_WIDTH-1:0] cmd_bursts,
    input  logic [RX_WD_DEPTH-1:0]      cmd_wd,
    input  logic                        abort,
    input  logic                        RX_done,
    input  logic                        watchdog_rx_trigger,
    output logic                        cmd_ready,
    output logic                        Clear_buff,
    output logic                        rx_wait_enable,
    output logic                        select_mode,
    output logic [BURST_SIZE_WIDTH-1:0] expected_bursts,
    output logic [RX_WD_DEPTH-1:0]      watchdog_rx_conf,
    output logic                        session_done,
    output logic                        session_err,
    output logic [1:0]                  err_code,
    output logic [1:0]                  retry_cnt
);

    localparam int              CW          = (CLEAR_CYCLES > 1) ? $clog2(CLEAR_CYCLES) : 1;
    localparam logic [CW-1:0]   CLR_LAST    = CW'(CLEAR_CYCLES - 1);
    localparam logic [1:0]      RETRY_LIMIT = 2'(MAX_RETRY);

    localparam logic [1:0] ERR_NONE  = 2'b00;
    localparam logic [1:0] ERR_WDOG  = 2'b01;
    localparam logic [1:0] ERR_ABORT = 2'b10;
    localparam logic [1:0] ERR_ZERO  = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_ARM,
        S_RECV,
        S_DONE,
        S_ERR
    } state_t;

    state_t                      state_q, state_d;
    logic [CW-1:0]               clr_cnt_q, clr_cnt_d;
    logic [1:0]                  retry_q, retry_d;
    logic [1:0]                  err_q, err_d;
    logic                        mode_q, mode_d;
    logic [BURST_SIZE_WIDTH-1:0] bursts_q, bursts_d;
    logic [RX_WD_DEPTH-1:0]      wd_q, wd_d;

    logic                        cmd_ready_q;
    logic                        clear_q;
    logic                        rxw_q;
    logic                        done_q;
    logic                        err_pulse_q;

    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        retry_d   = retry_q;
        err_d     = err_q;
        mode_d    = mode_q;
        bursts_d  = bursts_q;
        wd_d      = wd_q;

        case (state_q)
            S_IDLE: begin
                if (cmd_start) begin
                    mode_d    = cmd_mode;
                    bursts_d  = cmd_bursts;
                    wd_d      = cmd_wd;
                    retry_d   = 2'd0;
                    clr_cnt_d = '0;
                    // A zero-length session has nothing to receive, so skip the clear entirely.
                    if (cmd_bursts == '0) begin
                        err_d   = ERR_ZERO;
                        state_d = S_ERR;
                    end else begin
                        err_d   = ERR_NONE;
                        state_d = S_CLEAR;
                    end
                end
            end
            S_CLEAR: begin
                if (abort) begin
                    err_d   = ERR_ABORT;
                    state_d = S_ERR;
                end else if (clr_cnt_q == CLR_LAST) begin
                    state_d = S_ARM;
                end else begin
                    clr_cnt_d = clr_cnt_q + CW'(1);
                end
            end
            S_ARM: begin
                if (abort) begin
                    err_d   = ERR_ABORT;
                    state_d = S_ERR;
                end else begin
                    state_d = S_RECV;
                end
            end
            S_RECV: begin
                // Priority: abort, then completion, then watchdog.
                if (abort) begin
                    err_d   = ERR_ABORT;
                    state_d = S_ERR;
                end else if (RX_done) begin
                    state_d = S_DONE;
                end else if (watchdog_rx_trigger) begin
                    if (retry_q < RETRY_LIMIT) begin
                        retry_d   = retry_q + 2'd1;
                        clr_cnt_d = '0;
                        state_d   = S_CLEAR;
                    end else begin
                        err_d   = ERR_WDOG;
                        state_d = S_ERR;
                    end
                end
            end
            S_DONE:  state_d = S_IDLE;
            S_ERR:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs are decoded from the next state so every output is a flop.
    always_ff @(posedge clk_in) begin
        if (rst) begin
            state_q     <= S_IDLE;
            clr_cnt_q   <= '0;
            retry_q     <= 2'd0;
            err_q       <= ERR_NONE;
            mode_q      <= 1'b0;
            bursts_q    <= '0;
            wd_q        <= '0;
            cmd_ready_q <= 1'b1;
            clear_q     <= 1'b0;
            rxw_q       <= 1'b0;
            done_q      <= 1'b0;
            err_pulse_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            clr_cnt_q   <= clr_cnt_d;
            retry_q     <= retry_d;
            err_q       <= err_d;
            mode_q      <= mode_d;
            bursts_q    <= bursts_d;
            wd_q        <= wd_d;
            cmd_ready_q <= (state_d == S_IDLE);
            clear_q     <= (state_d == S_CLEAR);
            rxw_q       <= (state_d == S_RECV);
            done_q      <= (state_d == S_DONE);
            err_pulse_q <= (state_d == S_ERR);
        end
    end

    assign cmd_ready        = cmd_ready_q;
    assign Clear_buff       = clear_q;
    assign rx_wait_enable   = rxw_q;
    assign select_mode      = mode_q;
    assign expected_bursts  = bursts_q;
    assign watchdog_rx_conf = wd_q;
    assign session_done     = done_q;
    assign session_err      = err_pulse_q;
    assign err_code         = err_q;
    assign retry_cnt        = retry_q;

endmodule

// File: tb/tb_rx_session_ctrl.sv
// Scoreboard bench for rx_session_ctrl: expected session outcomes are queued at
// command time and retired when a session_done/session_err pulse appears.
module tb_rx_session_ctrl;

    localparam int BW = 16;
    localparam int WW = 4;
    localparam int MR = 2;
    localparam int CC = 2;

    logic          clk_in = 1'b0;
    logic          rst;
    logic          cmd_start;
    logic          cmd_mode;
    logic [BW-1:0] cmd_bursts;
    logic [WW-1:0] cmd_wd;
    logic          abort;
    logic          RX_done;
    logic          watchdog_rx_trigger;
    logic          cmd_ready;
    logic          Clear_buff;
    logic          rx_wait_enable;
    logic          select_mode;
    logic [BW-1:0] expected_bursts;
    logic [WW-1:0] watchdog_rx_conf;
    logic          session_done;
    logic          session_err;
    logic [1:0]    err_code;
    logic [1:0]    retry_cnt;

    rx_session_ctrl #(
        .BURST_SIZE_WIDTH (BW),
        .RX_WD_DEPTH      (WW),
        .MAX_RETRY        (MR),
        .CLEAR_CYCLES     (CC)
    ) dut (
        .clk_in              (clk_in),
        .rst                 (rst),
        .cmd_start           (cmd_start),
        .cmd_mode            (cmd_mode),
        .cmd_bursts          (cmd_bursts),
        .cmd_wd              (cmd_wd),
        .abort               (abort),
        .RX_done             (RX_done),
        .watchdog_rx_trigger (watchdog_rx_trigger),
        .cmd_ready           (cmd_ready),
        .Clear_buff          (Clear_buff),
        .rx_wait_enable      (rx_wait_enable),
        .select_mode         (select_mode),
        .expected_bursts     (expected_bursts),
        .watchdog_rx_conf    (watchdog_rx_conf),
        .session_done        (session_done),
        .session_err         (session_err),
        .err_code            (err_code),
        .retry_cnt           (retry_cnt)
    );

    always #5 clk_in = ~clk_in;

    typedef struct packed {
        logic       is_err;
        logic [1:0] code;
        logic [1:0] retry;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_errors = 0;
    int   clr_cnt  = 0;
    int   rxw_cnt  = 0;
    int   lat;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic exp_t mk(input logic is_err, input logic [1:0] code, input logic [1:0] retry);
        exp_t e;
        e.is_err = is_err;
        e.code   = code;
        e.retry  = retry;
        return e;
    endfunction

    // One clock: observe at the falling edge, tally strobes, retire pulses.
    task automatic cyc();
        exp_t e;
        @(negedge clk_in);
        if (Clear_buff === 1'b1) clr_cnt++;
        if (rx_wait_enable === 1'b1) rxw_cnt++;
        if (session_done === 1'b1 || session_err === 1'b1) begin
            if (sb_q.size() == 0) begin
                check_val("unexpected_pulse", {30'd0, session_done, session_err}, 32'd0);
            end else begin
                e = sb_q.pop_front();
                check_val("pulse_kind", {30'd0, session_done, session_err},
                          e.is_err ? 32'd1 : 32'd2);
                check_val("pulse_err_code", {30'd0, err_code}, {30'd0, e.code});
                check_val("pulse_retry_cnt", {30'd0, retry_cnt}, {30'd0, e.retry});
                $display("txn %s err_code=%0d retry_cnt=%0d t=%0t",
                         session_done ? "done" : "err", err_code, retry_cnt, $time);
            end
        end
    endtask

    task automatic start(input logic mode, input logic [BW-1:0] bursts, input logic [WW-1:0] wd);
        cmd_start  = 1'b1;
        cmd_mode   = mode;
        cmd_bursts = bursts;
        cmd_wd     = wd;
        clr_cnt    = 0;
        rxw_cnt    = 0;
        cyc();
        cmd_start  = 1'b0;
    endtask

    task automatic wait_rxw(input int budget, output int n);
        n = 0;
        while (rx_wait_enable !== 1'b1 && n < budget) begin
            cyc();
            n++;
        end
        if (rx_wait_enable !== 1'b1) check_val("rxw_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        rst = 1'b1;
        cmd_start = 1'b0;
        cmd_mode = 1'b0;
        cmd_bursts = '0;
        cmd_wd = '0;
        abort = 1'b0;
        RX_done = 1'b0;
        watchdog_rx_trigger = 1'b0;
        repeat (3) cyc();

        check_val("rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
        check_val("rst_clear", {31'd0, Clear_buff}, 32'd0);
        check_val("rst_rxw", {31'd0, rx_wait_enable}, 32'd0);
        check_val("rst_mode", {31'd0, select_mode}, 32'd0);
        check_val("rst_bursts", {16'd0, expected_bursts}, 32'd0);
        check_val("rst_wd", {28'd0, watchdog_rx_conf}, 32'd0);
        check_val("rst_err_code", {30'd0, err_code}, 32'd0);
        check_val("rst_retry", {30'd0, retry_cnt}, 32'd0);
        check_val("rst_pulses", {30'd0, session_done, session_err}, 32'd0);
        rst = 1'b0;
        cyc();

        // Normal session: 30 RECV cycles then RX_done.
        sb_q.push_back(mk(1'b0, 2'b00, 2'd0));
        start(1'b0, 16'd20, 4'd10);
        check_val("clear_first", {31'd0, Clear_buff}, 32'd1);
        check_val("busy_cmd_ready", {31'd0, cmd_ready}, 32'd0);
        wait_rxw(20, lat);
        check_val("start_latency", lat + 1, CC + 2);
        check_val("clear_len", clr_cnt, CC);
        check_val("cfg_mode", {31'd0, select_mode}, 32'd0);
        check_val("cfg_bursts", {16'd0, expected_bursts}, 32'd20);
        check_val("cfg_wd", {28'd0, watchdog_rx_conf}, 32'd10);
        repeat (29) cyc();
        check_val("rxw_len", rxw_cnt, 30);
        RX_done = 1'b1;
        cyc();
        RX_done = 1'b0;
        check_val("rxw_drop", {31'd0, rx_wait_enable}, 32'd0);
        cyc();
        check_val("done_idle", {31'd0, cmd_ready}, 32'd1);

        // Watchdog exhaustion: three triggers, two retries, then error.
        sb_q.push_back(mk(1'b1, 2'b01, 2'd2));
        start(1'b1, 16'd1, 4'd3);
        for (int i = 0; i < 3; i++) begin
            wait_rxw(20, lat);
            check_val("retry_latency", lat + 1, CC + 2);
            check_val("retry_before", {30'd0, retry_cnt}, i);
            watchdog_rx_trigger = 1'b1;
            cyc();
            watchdog_rx_trigger = 1'b0;
        end
        check_val("reclear_count", clr_cnt, 3 * CC);
        check_val("wd_err_rxw", {31'd0, rx_wait_enable}, 32'd0);
        check_val("wd_cfg_mode", {31'd0, select_mode}, 32'd1);
        cyc();

        // Strobes outside RECV ignored; one retry, then RX_done beats watchdog.
        sb_q.push_back(mk(1'b0, 2'b00, 2'd1));
        start(1'b0, 16'd5, 4'd2);
        watchdog_rx_trigger = 1'b1;
        RX_done = 1'b1;
        cyc();
        watchdog_rx_trigger = 1'b0;
        RX_done = 1'b0;
        check_val("wd_outside_recv", {30'd0, retry_cnt}, 32'd0);
        wait_rxw(20, lat);
        watchdog_rx_trigger = 1'b1;
        cyc();
        watchdog_rx_trigger = 1'b0;
        wait_rxw(20, lat);
        check_val("retry_one", {30'd0, retry_cnt}, 32'd1);
        RX_done = 1'b1;
        watchdog_rx_trigger = 1'b1;
        cyc();
        RX_done = 1'b0;
        watchdog_rx_trigger = 1'b0;
        check_val("tie_retry_kept", {30'd0, retry_cnt}, 32'd1);
        cyc();

        // Abort in IDLE ignored, abort in first CLEAR cycle.
        abort = 1'b1;
        cyc();
        abort = 1'b0;
        check_val("abort_idle", {31'd0, cmd_ready}, 32'd1);
        sb_q.push_back(mk(1'b1, 2'b10, 2'd0));
        start(1'b0, 16'd8, 4'd4);
        abort = 1'b1;
        cyc();
        abort = 1'b0;
        repeat (3) cyc();
        check_val("abort_no_rxw", rxw_cnt, 0);
        check_val("abort_idle_after", {31'd0, cmd_ready}, 32'd1);

        // Abort beats RX_done and watchdog in RECV.
        sb_q.push_back(mk(1'b1, 2'b10, 2'd0));
        start(1'b1, 16'd3, 4'd1);
        wait_rxw(20, lat);
        abort = 1'b1;
        RX_done = 1'b1;
        watchdog_rx_trigger = 1'b1;
        cyc();
        abort = 1'b0;
        RX_done = 1'b0;
        watchdog_rx_trigger = 1'b0;
        check_val("abort_prio_rxw", {31'd0, rx_wait_enable}, 32'd0);
        cyc();

        // Zero bursts, start during ERR ignored, error code held.
        sb_q.push_back(mk(1'b1, 2'b11, 2'd0));
        start(1'b0, 16'd0, 4'd5);
        cmd_start = 1'b1;
        cmd_bursts = 16'd9;
        cyc();
        cmd_start = 1'b0;
        check_val("zero_no_clear", clr_cnt, 0);
        check_val("busy_start_ignored", {16'd0, expected_bursts}, 32'd0);
        repeat (3) cyc();
        check_val("err_hold", {30'd0, err_code}, 32'd3);

        // Start while busy in RECV must not disturb the captured config.
        sb_q.push_back(mk(1'b0, 2'b00, 2'd0));
        start(1'b1, 16'd7, 4'd6);
        check_val("err_cleared", {30'd0, err_code}, 32'd0);
        wait_rxw(20, lat);
        cmd_start = 1'b1;
        cmd_mode = 1'b0;
        cmd_bursts = 16'd99;
        cmd_wd = 4'd1;
        repeat (3) cyc();
        cmd_start = 1'b0;
        check_val("busy_bursts", {16'd0, expected_bursts}, 32'd7);
        check_val("busy_mode", {31'd0, select_mode}, 32'd1);
        check_val("busy_wd", {28'd0, watchdog_rx_conf}, 32'd6);
        RX_done = 1'b1;
        cyc();
        RX_done = 1'b0;
        cyc();

        // Reset in RECV: everything back to reset values, no pulses.
        start(1'b1, 16'd12, 4'd9);
        wait_rxw(20, lat);
        rst = 1'b1;
        cyc();
        check_val("mid_rst_ready", {31'd0, cmd_ready}, 32'd1);
        check_val("mid_rst_rxw", {31'd0, rx_wait_enable}, 32'd0);
        check_val("mid_rst_clear", {31'd0, Clear_buff}, 32'd0);
        check_val("mid_rst_pulses", {30'd0, session_done, session_err}, 32'd0);
        check_val("mid_rst_bursts", {16'd0, expected_bursts}, 32'd0);
        check_val("mid_rst_mode", {31'd0, select_mode}, 32'd0);
        check_val("mid_rst_wd", {28'd0, watchdog_rx_conf}, 32'd0);
        rst = 1'b0;
        repeat (3) cyc();
        check_val("post_rst_ready", {31'd0, cmd_ready}, 32'd1);

        check_val("sb_drained", sb_q.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
